// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, reset coefficients and output narrowing for fir_filter_param
// Purpose: compile-time helpers shared by fir_filter_param and fir_coef_bank.
// Ports: none (package).
// Macro FIR_SAT_EN: defined -> round_narrow clamps to the signed out_w range;
//                   undefined -> round_narrow keeps the low out_w bits (wrap).
package fir_pkg;

  // Working type for rounding and narrowing. It must be wider than the
  // accumulator so that the rounding add can never overflow.
  typedef logic signed [63:0] wide_t;

  // Only tap 0 comes out of reset non-zero, which makes the filter a passthrough.
  localparam int COEF_RESET_TAP0 = 1;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int coef_reset(input int k);
    return (k == 0) ? COEF_RESET_TAP0 : 0;
  endfunction

  // Round half up, arithmetic shift, then narrow to out_w bits.
  // The result is sign-extended back to wide_t so callers only truncate.
  function automatic wide_t round_narrow(input wide_t acc, input int shift, input int out_w);
    wide_t r;
`ifdef FIR_SAT_EN
    wide_t hi;
    wide_t lo;
`endif
    r = acc;
    if (shift > 0) r = r + (wide_t'(1) <<< (shift - 1));
    r = r >>> shift;
`ifdef FIR_SAT_EN
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`else
    r = (r <<< (64 - out_w)) >>> (64 - out_w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - runtime-writable coefficient register file for fir_filter_param
// Purpose: holds TAPS signed coefficients; reset value is passthrough (c[0]=1).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   coef_we           write strobe
//   coef_addr         tap index; addresses >= TAPS match no entry and are dropped
//   coef_wdata        signed coefficient value
//   coefs             all coefficients, tap k at [k*COEF_W +: COEF_W]
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int COEF_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic [TAPS*COEF_W-1:0]    coefs
);

  logic signed [COEF_W-1:0] coef_q [TAPS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= COEF_W'(coef_reset(k));
    end else if (coef_we) begin
      // Per-entry compare: an out-of-range address simply matches nothing.
      for (int k = 0; k < TAPS; k++) begin
        if (int'(coef_addr) == k) coef_q[k] <= coef_wdata;
      end
    end
  end

  always_comb begin
    coefs = '0;
    for (int k = 0; k < TAPS; k++) coefs[k*COEF_W +: COEF_W] = coef_q[k];
  end

endmodule

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - parametrised two-stage pipelined signed FIR filter
// Purpose: y = sum c[k]*x[n-k], rounded by SHIFT and narrowed to OUT_W.
//   Stage 1 registers the TAPS products of the shifted delay line,
//   stage 2 registers the summed, rounded, narrowed result.
//   Latency 2 cycles, one sample per cycle, gaps preserved.
// Macro FIR_SAT_EN: defined -> saturating narrow; undefined -> wrapping narrow.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (all state incl. coefficients)
//   clear             synchronous flush of delay line and pipeline; coefficients kept
//   in_valid, in_data signed input sample qualifier and value
//   coef_we, coef_addr, coef_wdata  coefficient write port
//   out_valid         one-cycle pulse per result
//   out_data          signed result, held while out_valid is low
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  logic [TAPS*COEF_W-1:0]   coefs;
  logic signed [DATA_W-1:0] line_q [TAPS];
  logic signed [DATA_W-1:0] line_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  out_d;

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk        (clk),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coefs      (coefs)
  );

  // Products use the line as it will be after this sample shifts in, and the
  // coefficients before any write on this same edge takes effect.
  always_comb begin
    line_d[0] = in_data;
    for (int k = 1; k < TAPS; k++) line_d[k] = line_q[k-1];
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PROD_W'(line_d[k]) * PROD_W'($signed(coefs[k*COEF_W +: COEF_W]));
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod_q[k]);
    out_d = OUT_W'(round_narrow(wide_t'(acc), SHIFT, OUT_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q     <= '{default: '0};
      prod_q     <= '{default: '0};
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (clear) begin
      // out_data is left alone: it only ever changes together with out_valid.
      line_q     <= '{default: '0};
      prod_q     <= '{default: '0};
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (in_valid) begin
        line_q <= line_d;
        prod_q <= prod_d;
      end
      prod_valid <= in_valid;
      out_valid  <= prod_valid;
      if (prod_valid) out_data <= out_d;
    end
  end

endmodule
